line_capture_ctrl: RTL and testbench
====================================

// Module: line_capture_ctrl
// PURPOSE
//  Write-side sequencer for the line RAM and histogram RAM that the CPU reads through the video-memory port.
//  - Stores each visible pixel into the active half of the line RAM.
//  - Bins each visible pixel into the active half of the histogram RAM with a read-modify-write.
//  - Clears the newly active histogram half during vblank.
//  - Ping-pongs both buffers. which_line / which_histo tell the CPU which half is complete and stable.
// PARAMETERS
//  PIX_W      12  pixel width
//  COL_W      9   column index width (512 pixels per line half)
//  BIN_W      8   histogram bin index width (256 bins per half)
//  BIN_SHIFT  4   bin = pixel >> BIN_SHIFT
//  CNT_W      27  histogram counter width
// PORTS
//  clk                 in   1      clock
//  rst                 in   1      reset, synchronous, active-low
//  vid_pixel           in   12     pixel value, valid when vid_pixsync=1
//  vid_pixsync         in   1      one-cycle pixel strobe
//  vid_hblank          in   1      horizontal blank
//  vid_vblank          in   1      vertical blank
//  vid_visible         in   1      pixel in active area
//  lr_wren             out  1      line RAM write enable
//  lr_addr             out  10     line RAM write address {line_bank, col}
//  lr_data             out  12     line RAM write data
//  hr_wren             out  1      histogram port-A write enable
//  hr_addr             out  9      histogram port-A address {histo_bank, bin}
//  hr_data             out  27     histogram port-A write data
//  hr_q                in   27     histogram port-A read data, 1-cycle registered latency
//  status_which_line   out  1      line half the CPU may read (= ~line_bank)
//  status_which_histo  out  1      histogram half the CPU may read (= ~histo_bank)
//  err_overrun         out  1      sticky flag for a dropped pixel; cleared only by reset
// BEHAVIOUR
//  Reset (rst=0 at a clk edge)
//  - All outputs are 0 except status_which_line=1 and status_which_histo=1.
//  - line_bank=0, histo_bank=0, col=0.
//  - The FSM enters CLEAR with clr_idx=0.
//  Accepted pixel: vid_pixsync & vid_visible & ~vid_hblank & ~vid_vblank.
//  Line path
//  - Accepted pixel with col<511: in the same cycle drive lr_wren=1, lr_addr={line_bank,col}, lr_data=vid_pixel; col increments.
//  - Accepted pixel with col=511: it is written, then col saturates at 511. Later pixels on that line are dropped and do not set err.
//  - Rising edge of vid_hblank: line_bank toggles, col<=0, status_which_line<=old line_bank, all on the next cycle.
//  FSM states: CLEAR, RUN
//  - CLEAR: each cycle drives hr_wren=1, hr_addr={histo_bank,clr_idx}, hr_data=0, then clr_idx++.
//    After clr_idx=255 is written, next state is RUN. Accepted pixels still go to the line RAM.
//    Their histogram update is dropped and err_overrun<=1.
//  - RUN: 2-cycle RMW per accepted pixel.
//    Cycle t: hr_addr={histo_bank, pixel[11:4]}, hr_wren=0; the bin is latched.
//    Cycle t+1: hr_wren=1, same hr_addr, hr_data = (hr_q==2^27-1) ? hr_q : hr_q+1 (saturating).
//  - RUN to CLEAR on the rising edge of vid_vblank: histo_bank toggles, status_which_histo<=old histo_bank, clr_idx<=0.
//    If an RMW is in flight, its write at t+1 completes to the old bank first, then CLEAR begins the next cycle.
//  - The clear must fit inside vblank (>=256 cycles). If vblank ends early, CLEAR still runs to completion and drops pixels as above.
//  Pixel spacing
//  - vid_pixsync is guaranteed at most once per 2 clk cycles.
//  - A strobe in the write cycle t+1 of an RMW is dropped from the histogram and sets err_overrun. The line write still happens.
//  - With that spacing, back-to-back pixels in the same bin need no forwarding: the write at t+1 precedes the read at t+2.
//  Simultaneous events
//  - A pixel strobe together with a blank edge is not accepted, because blank is high.
//  - A vblank rise together with an hblank rise applies both toggles in the same cycle.
//  Reset mid-operation: any in-flight RMW is abandoned. The bin may be left unincremented; it is cleared by the following CLEAR.
// STRUCTURE
//  - Package camerica_pkg: PIX_W, COL_W, BIN_W, CNT_W, BIN_SHIFT; typedef enum logic {ST_CLEAR, ST_RUN} histo_state_t.
//  - One sub-module, histo_rmw: CLEAR/RUN FSM, clear counter, 2-cycle RMW and saturating adder.
//  - Line path, edge detectors and status registers stay in line_capture_ctrl.
// TESTING
//  1. Reset, hold video idle -> 256 clear writes to addr 0..255 with data 0; status_which_histo=1; then RUN.
//  2. One line of 600 pixels, value 0x123, pixsync every 2 clks, then hblank rise
//     -> lr_addr 0..511 written (512 writes only); status_which_line=0; col resets.
//  3. Pixels 0x010,0x01F,0x020 with hr_q model
//     -> bins 1,1,2 incremented; bin 1 ends at 2; no err.
//  4. Preload bin 5 = 0x7FFFFFF, send pixel 0x050 -> written value stays 0x7FFFFFF.
//  5. pixsync on consecutive clks in RUN -> second pixel is line-written only; err_overrun=1 and sticky until rst=0.
//  6. vblank rises during an RMW on bank 0 -> write to bank 0 completes, then clear starts at 0x100..0x1FF; status_which_histo=0.

Source files
------------

// File: rtl/camerica_pkg.sv
// Shared widths, FSM state type and the saturating counter helper for the
// line / histogram capture path.
package camerica_pkg;

  localparam int PIX_W     = 12;
  localparam int COL_W     = 9;
  localparam int BIN_W     = 8;
  localparam int BIN_SHIFT = 4;
  localparam int CNT_W     = 27;

  typedef enum logic {ST_CLEAR, ST_RUN} histo_state_t;

  // Histogram bins stick at full scale instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/line_capture_ctrl_histo_rmw.sv
// Histogram write port sequencer: clears the freshly active half after a
// vblank swap, then bins accepted pixels with a two-cycle read-modify-write.
module histo_rmw
  import camerica_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [BIN_W-1:0] pix_bin,
  input  logic             vblank_rise,
  input  logic [CNT_W-1:0] hr_q,
  output logic             hr_wren,
  output logic [BIN_W:0]   hr_addr,
  output logic [CNT_W-1:0] hr_data,
  output logic             histo_bank,
  output logic             bank_swap,
  output logic             err_overrun
);

  histo_state_t     state, state_nxt;
  logic [BIN_W-1:0] clr_idx;
  logic [BIN_W-1:0] bin_q;
  logic             pend;
  logic             start_rmw;
  logic             drop;

  // Next state, RAM port drive and drop detection; a vblank swap is taken
  // at the same edge as an in-flight write, so that write still lands in
  // the old bank.
  always_comb begin
    state_nxt = state;
    hr_wren   = 1'b0;
    hr_addr   = {histo_bank, bin_q};
    hr_data   = '0;
    start_rmw = 1'b0;
    drop      = 1'b0;
    bank_swap = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        hr_wren = 1'b1;
        hr_addr = {histo_bank, clr_idx};
        drop    = accept;
        if (clr_idx == '1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (pend) begin
          hr_wren = 1'b1;
          hr_data = sat_inc(hr_q);
          drop    = accept;
        end else if (accept) begin
          hr_addr   = {histo_bank, pix_bin};
          start_rmw = 1'b1;
        end
        if (vblank_rise) begin
          bank_swap = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
    endcase
    if (!rst) begin
      hr_wren   = 1'b0;
      hr_addr   = '0;
      hr_data   = '0;
      bank_swap = 1'b0;
    end
  end

  // State, clear counter, latched bin, bank select and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_CLEAR;
      clr_idx     <= '0;
      bin_q       <= '0;
      pend        <= 1'b0;
      histo_bank  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_idx <= clr_idx + BIN_W'(1);
      else if (bank_swap)    clr_idx <= '0;
      pend <= start_rmw;
      if (start_rmw) bin_q <= pix_bin;
      if (bank_swap) histo_bank <= ~histo_bank;
      if (drop) err_overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/line_capture_ctrl.sv
// Write-side sequencer for the ping-pong line RAM and histogram RAM read by
// the CPU. Line path, blank edge detection and CPU status live here.
module line_capture_ctrl
  import camerica_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] vid_pixel,
  input  logic             vid_pixsync,
  input  logic             vid_hblank,
  input  logic             vid_vblank,
  input  logic             vid_visible,
  output logic             lr_wren,
  output logic [COL_W:0]   lr_addr,
  output logic [PIX_W-1:0] lr_data,
  output logic             hr_wren,
  output logic [BIN_W:0]   hr_addr,
  output logic [CNT_W-1:0] hr_data,
  input  logic [CNT_W-1:0] hr_q,
  output logic             status_which_line,
  output logic             status_which_histo,
  output logic             err_overrun
);

  logic             hblank_q;
  logic             vblank_q;
  logic             line_bank;
  logic             line_done;
  logic [COL_W-1:0] col;
  logic             accept;
  logic             hblank_rise;
  logic             vblank_rise;
  logic             histo_bank;
  logic             histo_swap;

  // Pixel acceptance, blank edges and the combinational line RAM write.
  always_comb begin
    accept      = vid_pixsync & vid_visible & ~vid_hblank & ~vid_vblank;
    hblank_rise = vid_hblank & ~hblank_q;
    vblank_rise = vid_vblank & ~vblank_q;
    lr_wren     = rst & accept & ~line_done;
    lr_addr     = lr_wren ? {line_bank, col} : '0;
    lr_data     = lr_wren ? vid_pixel : '0;
  end

  // Column tracking, line bank ping-pong and CPU-visible status halves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hblank_q           <= 1'b0;
      vblank_q           <= 1'b0;
      line_bank          <= 1'b0;
      line_done          <= 1'b0;
      col                <= '0;
      status_which_line  <= 1'b1;
      status_which_histo <= 1'b1;
    end else begin
      hblank_q <= vid_hblank;
      vblank_q <= vid_vblank;
      if (hblank_rise) begin
        line_bank         <= ~line_bank;
        col               <= '0;
        line_done         <= 1'b0;
        status_which_line <= line_bank;
      end else if (lr_wren) begin
        if (col == '1) line_done <= 1'b1;
        else           col       <= col + COL_W'(1);
      end
      if (histo_swap) status_which_histo <= histo_bank;
    end
  end

  histo_rmw u_histo_rmw (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept),
    .pix_bin     (vid_pixel[BIN_SHIFT +: BIN_W]),
    .vblank_rise (vblank_rise),
    .hr_q        (hr_q),
    .hr_wren     (hr_wren),
    .hr_addr     (hr_addr),
    .hr_data     (hr_data),
    .histo_bank  (histo_bank),
    .bank_swap   (histo_swap),
    .err_overrun (err_overrun)
  );

endmodule

// File: tb/tb_line_capture_ctrl.sv
// Directed bench for line_capture_ctrl with a behavioural histogram RAM
// (registered read) answering on hr_q.
module tb_line_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vid_pixel;
  logic        vid_pixsync;
  logic        vid_hblank;
  logic        vid_vblank;
  logic        vid_visible;
  logic        lr_wren;
  logic [9:0]  lr_addr;
  logic [11:0] lr_data;
  logic        hr_wren;
  logic [8:0]  hr_addr;
  logic [26:0] hr_data;
  logic [26:0] hr_q;
  logic        status_which_line;
  logic        status_which_histo;
  logic        err_overrun;

  logic [26:0] histo_mem [0:511];
  logic        preload_en = 1'b0;
  logic [8:0]  preload_addr = '0;
  logic [26:0] preload_val = '0;
  int          lr_count = 0;
  int          lr_base;
  int          vectors = 0;
  int          miscompares = 0;

  line_capture_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .vid_pixel          (vid_pixel),
    .vid_pixsync        (vid_pixsync),
    .vid_hblank         (vid_hblank),
    .vid_vblank         (vid_vblank),
    .vid_visible        (vid_visible),
    .lr_wren            (lr_wren),
    .lr_addr            (lr_addr),
    .lr_data            (lr_data),
    .hr_wren            (hr_wren),
    .hr_addr            (hr_addr),
    .hr_data            (hr_data),
    .hr_q               (hr_q),
    .status_which_line  (status_which_line),
    .status_which_histo (status_which_histo),
    .err_overrun        (err_overrun)
  );

  always #5 clk = ~clk;

  // Histogram RAM model: write port A, registered read of the same address.
  always @(posedge clk) begin
    if (preload_en)   histo_mem[preload_addr] <= preload_val;
    else if (hr_wren) histo_mem[hr_addr] <= hr_data;
    hr_q <= histo_mem[hr_addr];
  end

  // Running count of line RAM writes.
  always @(posedge clk) begin
    if (lr_wren) lr_count <= lr_count + 1;
  end

  task automatic applyStimulus(input logic [11:0] pix, input logic sync,
                               input logic hb, input logic vb, input logic vis);
    vid_pixel   = pix;
    vid_pixsync = sync;
    vid_hblank  = hb;
    vid_vblank  = vb;
    vid_visible = vis;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendPixel(input string tag, input logic [11:0] pix,
                           input logic [9:0] exp_lr_addr, input logic [8:0] exp_addr,
                           input logic [26:0] exp_data);
    nextCycle();
    applyStimulus(pix, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_lr_wren"}, 32'(lr_wren), 32'd1);
    checkOutput({tag, "_lr_addr"}, 32'(lr_addr), 32'(exp_lr_addr));
    checkOutput({tag, "_rd_wren"}, 32'(hr_wren), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(hr_addr), 32'(exp_addr));
    nextCycle();
    applyStimulus(pix, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_wr_wren"}, 32'(hr_wren), 32'd1);
    checkOutput({tag, "_wr_addr"}, 32'(hr_addr), 32'(exp_addr));
    checkOutput({tag, "_wr_data"}, 32'(hr_data), 32'(exp_data));
  endtask

  initial begin
    // Reset with video idle
    rst = 1'b0;
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_lr_wren", 32'(lr_wren), 32'd0);
    checkOutput("rst_hr_wren", 32'(hr_wren), 32'd0);
    checkOutput("rst_hr_addr", 32'(hr_addr), 32'd0);
    checkOutput("rst_which_line", 32'(status_which_line), 32'd1);
    checkOutput("rst_which_histo", 32'(status_which_histo), 32'd1);
    checkOutput("rst_err", 32'(err_overrun), 32'd0);
    nextCycle();
    rst = 1'b1;

    // Initial clear of bank 0
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      checkOutput("clr0_wren", 32'(hr_wren), 32'd1);
      checkOutput("clr0_addr", 32'(hr_addr), 32'(i));
      checkOutput("clr0_data", 32'(hr_data), 32'd0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("run_idle_wren", 32'(hr_wren), 32'd0);
    checkOutput("run_which_histo", 32'(status_which_histo), 32'd1);

    // One 600-pixel line, only 512 columns written
    lr_base = lr_count;
    for (int k = 0; k < 600; k++) begin
      nextCycle();
      applyStimulus(12'h123, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("line_wren", 32'(lr_wren), (k < 512) ? 32'd1 : 32'd0);
      if (k < 512) begin
        checkOutput("line_addr", 32'(lr_addr), 32'(k));
        checkOutput("line_data", 32'(lr_data), 32'h123);
      end
      nextCycle();
      applyStimulus(12'h123, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("line_write_count", 32'(lr_count - lr_base), 32'd512);
    checkOutput("bin12_count", 32'(histo_mem[9'h012]), 32'd600);
    checkOutput("line_err", 32'(err_overrun), 32'd0);

    // hblank rise swaps the line bank
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hblank_which_line", 32'(status_which_line), 32'd0);

    // Bin increments, col restarted in bank 1
    sendPixel("px010", 12'h010, 10'h200, 9'h001, 27'd1);
    sendPixel("px01F", 12'h01F, 10'h201, 9'h001, 27'd2);
    sendPixel("px020", 12'h020, 10'h202, 9'h002, 27'd1);
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bin1_final", 32'(histo_mem[9'h001]), 32'd2);
    checkOutput("bin2_final", 32'(histo_mem[9'h002]), 32'd1);
    checkOutput("bins_err", 32'(err_overrun), 32'd0);

    // Saturation of a full-scale bin
    nextCycle();
    preload_addr = 9'h005;
    preload_val  = 27'h7FFFFFF;
    preload_en   = 1'b1;
    nextCycle();
    preload_en   = 1'b0;
    sendPixel("sat", 12'h050, 10'h203, 9'h005, 27'h7FFFFFF);
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sat_mem", 32'(histo_mem[9'h005]), 32'h7FFFFFF);

    // Strobes on consecutive clocks: second one is line-only
    nextCycle();
    applyStimulus(12'h030, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ovr_rd_addr", 32'(hr_addr), 32'h003);
    nextCycle();
    applyStimulus(12'h040, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ovr_lr_wren", 32'(lr_wren), 32'd1);
    checkOutput("ovr_lr_addr", 32'(lr_addr), 32'h205);
    checkOutput("ovr_wr_wren", 32'(hr_wren), 32'd1);
    checkOutput("ovr_wr_addr", 32'(hr_addr), 32'h003);
    checkOutput("ovr_wr_data", 32'(hr_data), 32'd1);
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovr_err", 32'(err_overrun), 32'd1);
    checkOutput("ovr_no_rmw", 32'(hr_wren), 32'd0);
    repeat (5) nextCycle();
    @(negedge clk);
    checkOutput("ovr_err_sticky", 32'(err_overrun), 32'd1);
    checkOutput("ovr_bin4", 32'(histo_mem[9'h004]), 32'd0);
    checkOutput("ovr_bin3", 32'(histo_mem[9'h003]), 32'd1);

    // vblank rise during the write cycle of an RMW on bank 0
    nextCycle();
    applyStimulus(12'h070, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("vb_rd_addr", 32'(hr_addr), 32'h007);
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("vb_wr_wren", 32'(hr_wren), 32'd1);
    checkOutput("vb_wr_addr", 32'(hr_addr), 32'h007);
    checkOutput("vb_wr_data", 32'(hr_data), 32'd1);
    for (int i = 0; i < 256; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("clr1_wren", 32'(hr_wren), 32'd1);
      checkOutput("clr1_addr", 32'(hr_addr), 32'h100 + 32'(i));
      checkOutput("clr1_data", 32'(hr_data), 32'd0);
    end
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("vb_run_wren", 32'(hr_wren), 32'd0);
    checkOutput("vb_which_histo", 32'(status_which_histo), 32'd0);
    checkOutput("vb_bin7_old_bank", 32'(histo_mem[9'h007]), 32'd1);
    checkOutput("vb_clr_last", 32'(histo_mem[9'h1FF]), 32'd0);

    // Reset clears the sticky error and restores status
    nextCycle();
    rst = 1'b0;
    nextCycle();
    @(negedge clk);
    checkOutput("rst2_err", 32'(err_overrun), 32'd0);
    checkOutput("rst2_which_line", 32'(status_which_line), 32'd1);
    checkOutput("rst2_which_histo", 32'(status_which_histo), 32'd1);
    checkOutput("rst2_hr_wren", 32'(hr_wren), 32'd0);

    // Pixel during CLEAR: line write only, histogram drop flags overrun
    nextCycle();
    rst = 1'b1;
    applyStimulus(12'h0A0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("clrpx_lr_wren", 32'(lr_wren), 32'd1);
    checkOutput("clrpx_lr_addr", 32'(lr_addr), 32'h000);
    checkOutput("clrpx_lr_data", 32'(lr_data), 32'h0A0);
    checkOutput("clrpx_hr_addr", 32'(hr_addr), 32'h000);
    nextCycle();
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("clrpx_err", 32'(err_overrun), 32'd1);
    checkOutput("clrpx_next_addr", 32'(hr_addr), 32'h001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
